// File: rtl/sonic_cb_ring_mem.sv
// sonic_cb_ring_mem: NUM_CH circular buffers carved out of one simple dual-port RAM.
// Each ring owns 2^DEPTH_LOG2 entries, addressed as {ch, ptr[DEPTH_LOG2-1:0]}.
// Optional macro SONIC_CB_OVERWRITE_EN: full rings keep accepting writes and drop
// their oldest entry, counted per ring on drop_cnt.
module sonic_cb_ring_mem #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 11,
  parameter int AF_THRESH  = 2040
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  input  logic [$clog2(NUM_CH)-1:0]         wr_ch,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              wr_ready,
  input  logic                              rd_valid,
  input  logic [$clog2(NUM_CH)-1:0]         rd_ch,
  output logic                              rd_ready,
  output logic                              rd_data_valid,
  output logic [$clog2(NUM_CH)-1:0]         rd_data_ch,
  output logic [DATA_W-1:0]                 rd_data,
  input  logic [NUM_CH-1:0]                 flush,
  output logic [NUM_CH-1:0]                 empty,
  output logic [NUM_CH-1:0]                 full,
  output logic [NUM_CH-1:0]                 almost_full,
  output logic [NUM_CH*(DEPTH_LOG2+1)-1:0]  count
`ifdef SONIC_CB_OVERWRITE_EN
  ,
  output logic [NUM_CH*16-1:0]              drop_cnt
`endif
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PW     = DEPTH_LOG2 + 1;
  localparam int AW     = CH_W + DEPTH_LOG2;
  localparam int STAGES = 2;
  localparam logic [PW-1:0] FULL_CNT = PW'(1) << DEPTH_LOG2;
  localparam logic [PW-1:0] AF_CNT   = PW'(AF_THRESH);

  logic [PW-1:0]         r_wr_ptr [NUM_CH];
  logic [PW-1:0]         r_rd_ptr [NUM_CH];
  logic [PW-1:0]         w_wr_nxt [NUM_CH];
  logic [PW-1:0]         w_rd_nxt [NUM_CH];
  logic [PW-1:0]         w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]     r_empty, r_full, r_af;
  logic [NUM_CH*PW-1:0]  r_count;
  logic                  w_wr_acc, w_rd_acc;
  logic [AW-1:0]         w_waddr, w_raddr;

  logic [DATA_W-1:0]     r_mem [0:(2**AW)-1];
  logic [DATA_W-1:0]     r_ram_q;
  logic [STAGES:1]       r_vld_pipe;
  logic [CH_W-1:0]       r_ch_s1;
  logic [CH_W-1:0]       r_rd_data_ch;
  logic [DATA_W-1:0]     r_rd_data;

`ifdef SONIC_CB_OVERWRITE_EN
  logic [NUM_CH-1:0]     w_drop;
  logic [15:0]           r_drop [NUM_CH];
  assign wr_ready = !flush[wr_ch];
`else
  assign wr_ready = !r_full[wr_ch] & !flush[wr_ch];
`endif
  assign rd_ready = !r_empty[rd_ch] & !flush[rd_ch];
  assign w_wr_acc = wr_valid & wr_ready;
  assign w_rd_acc = rd_valid & rd_ready;
  assign w_waddr  = {wr_ch, r_wr_ptr[wr_ch][DEPTH_LOG2-1:0]};
  assign w_raddr  = {rd_ch, r_rd_ptr[rd_ch][DEPTH_LOG2-1:0]};

  assign empty         = r_empty;
  assign full          = r_full;
  assign almost_full   = r_af;
  assign count         = r_count;
  assign rd_data_valid = r_vld_pipe[STAGES];
  assign rd_data_ch    = r_rd_data_ch;
  assign rd_data       = r_rd_data;

  // Next pointer values per ring; flush snaps rd_ptr onto wr_ptr (ready is low for that ring).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr_nxt[i] = r_wr_ptr[i];
      w_rd_nxt[i] = r_rd_ptr[i];
`ifdef SONIC_CB_OVERWRITE_EN
      w_drop[i]   = 1'b0;
`endif
      if (flush[i]) begin
        w_rd_nxt[i] = r_wr_ptr[i];
      end else begin
        if (w_wr_acc && wr_ch == CH_W'(i))
          w_wr_nxt[i] = r_wr_ptr[i] + PW'(1);
        if (w_rd_acc && rd_ch == CH_W'(i))
          w_rd_nxt[i] = r_rd_ptr[i] + PW'(1);
`ifdef SONIC_CB_OVERWRITE_EN
        // Full ring written without a same-cycle pop: advance the tail too.
        else if (w_wr_acc && wr_ch == CH_W'(i) && r_full[i]) begin
          w_rd_nxt[i] = r_rd_ptr[i] + PW'(1);
          w_drop[i]   = 1'b1;
        end
`endif
      end
      w_cnt_nxt[i] = w_wr_nxt[i] - w_rd_nxt[i];
    end
  end

  // Pointer state and status flags, status registered from next-pointer values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
      r_empty <= '1;
      r_full  <= '0;
      r_af    <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i]          <= w_wr_nxt[i];
        r_rd_ptr[i]          <= w_rd_nxt[i];
        r_empty[i]           <= (w_cnt_nxt[i] == '0);
        r_full[i]            <= (w_cnt_nxt[i] == FULL_CNT);
        r_af[i]              <= (w_cnt_nxt[i] >= AF_CNT);
        r_count[i*PW +: PW]  <= w_cnt_nxt[i];
      end
    end
  end

  // Shared RAM: one write, one registered read per cycle; read returns old data on collision.
  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[w_waddr] <= wr_data;
    if (w_rd_acc)
      r_ram_q <= r_mem[w_raddr];
  end

  // Read return pipeline: RAM output stage, then output register (latency 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe   <= '0;
      r_ch_s1      <= '0;
      r_rd_data_ch <= '0;
      r_rd_data    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_rd_acc};
      if (w_rd_acc)
        r_ch_s1 <= rd_ch;
      if (r_vld_pipe[1]) begin
        r_rd_data    <= r_ram_q;
        r_rd_data_ch <= r_ch_s1;
      end
    end
  end

`ifdef SONIC_CB_OVERWRITE_EN
  // Per-ring saturating count of entries lost to overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++)
        r_drop[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_drop[i] && r_drop[i] != 16'hFFFF)
          r_drop[i] <= r_drop[i] + 16'd1;
    end
  end

  // Flatten drop counters onto the output bus.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      drop_cnt[i*16 +: 16] = r_drop[i];
  end
`endif

endmodule

// File: tb/tb_sonic_cb_ring_mem.sv
// Bench for sonic_cb_ring_mem: per-ring data queues model the rings, expected read
// returns go into a scoreboard queue that a negedge monitor drains.
module tb_sonic_cb_ring_mem;
  localparam int NCH = 4;
  localparam int DL2 = 3;
  localparam int DEPTH = 8;
  localparam int AFT = 6;

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        rd_valid = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic        rd_ready;
  logic        rd_data_valid;
  logic [1:0]  rd_data_ch;
  logic [7:0]  rd_data;
  logic [3:0]  flush = '0;
  logic [3:0]  empty, full, almost_full;
  logic [15:0] count;
`ifdef SONIC_CB_OVERWRITE_EN
  logic [63:0] drop_cnt;
`endif

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] mq [NCH][$];
  exp_t       exp_q [$];
  int         drops [NCH];

  sonic_cb_ring_mem #(.NUM_CH(NCH), .DATA_W(8), .DEPTH_LOG2(DL2), .AF_THRESH(AFT)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data_ch(rd_data_ch), .rd_data(rd_data),
    .flush(flush), .empty(empty), .full(full), .almost_full(almost_full), .count(count)
`ifdef SONIC_CB_OVERWRITE_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Status outputs derived from the occupancy of each model ring.
  task automatic check_status();
    logic [3:0]  e_em, e_fu, e_af;
    logic [15:0] e_cnt;
`ifdef SONIC_CB_OVERWRITE_EN
    logic [63:0] e_drop;
`endif
    for (int i = 0; i < NCH; i++) begin
      e_em[i] = (mq[i].size() == 0);
      e_fu[i] = (mq[i].size() == DEPTH);
      e_af[i] = (mq[i].size() >= AFT);
      e_cnt[i*4 +: 4] = 4'(mq[i].size());
`ifdef SONIC_CB_OVERWRITE_EN
      e_drop[i*16 +: 16] = 16'(drops[i]);
`endif
    end
    check("empty", empty, e_em);
    check("full", full, e_fu);
    check("almost_full", almost_full, e_af);
    check("count", count, e_cnt);
`ifdef SONIC_CB_OVERWRITE_EN
    check("drop_cnt", drop_cnt, e_drop);
`endif
  endtask

  // One clock of stimulus: drive, check readiness against the model, update model, check status.
  task automatic cyc_op(input bit wv, input int wc, input logic [7:0] wd,
                        input bit rv, input int rc, input logic [3:0] fl);
    bit         wexp, rexp;
    exp_t       e;
    wr_valid = wv; wr_ch = 2'(wc); wr_data = wd;
    rd_valid = rv; rd_ch = 2'(rc); flush = fl;
    #1;
`ifdef SONIC_CB_OVERWRITE_EN
    wexp = !fl[wc];
`else
    wexp = (mq[wc].size() < DEPTH) && !fl[wc];
`endif
    rexp = (mq[rc].size() > 0) && !fl[rc];
    check("wr_ready", wr_ready, wexp);
    check("rd_ready", rd_ready, rexp);
    if (rv && rexp) begin
      e.cyc = cyc + 2;
      e.ch  = rc;
      e.d   = mq[rc].pop_front();
      exp_q.push_back(e);
    end
    if (wv && wexp) begin
      if (mq[wc].size() == DEPTH) begin
        void'(mq[wc].pop_front());
        if (drops[wc] < 65535) drops[wc]++;
      end
      mq[wc].push_back(wd);
    end
    for (int i = 0; i < NCH; i++)
      if (fl[i]) mq[i].delete();
    @(posedge clk);
    @(negedge clk);
    check_status();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc_op(0, 0, 8'h00, 0, 0, 4'b0000);
  endtask

  task automatic drain(input int ch);
    for (int k = 0; k < 2*DEPTH && mq[ch].size() > 0; k++) cyc_op(0, 0, 8'h00, 1, ch, 4'b0000);
  endtask

  // Monitor: every returned beat must match the oldest expected pop, at accept+2.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rd_data_valid) begin
        if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e.d);
          check("rd_data_ch", rd_data_ch, 64'(e.ch));
          check("rd_latency", 64'(cyc), 64'(e.cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("rd_missing", 0, 1);
      end
    end
  end

  initial begin
    for (int i = 0; i < NCH; i++) drops[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", rd_data_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_ch", rd_data_ch, 0);
    check_status();
    rst = 1'b0;

    // Fill ring 2, then one more write must be refused (base build).
    for (int k = 0; k < DEPTH; k++) cyc_op(1, 2, 8'(8'h10 + k), 0, 0, 4'b0000);
    check("full2", full[2], 1);
    check("count2", count[11:8], 8);
`ifndef SONIC_CB_OVERWRITE_EN
    wr_valid = 1'b1; wr_ch = 2'd2; #1;
    check("wr_ready_full2", wr_ready, 0);
`endif
    cyc_op(1, 2, 8'h99, 0, 0, 4'b0000);

    // Back-to-back pops of ring 2.
    for (int k = 0; k < DEPTH; k++) cyc_op(0, 0, 8'h00, 1, 2, 4'b0000);
    idle(3);
    check("empty2", empty[2], 1);

    // Interleave rings 0 and 3 with pops; 20 writes each so both pointers wrap.
    for (int k = 0; k < 20; k++) begin
      cyc_op(1, 0, 8'(8'hA0 + k), 1, 3, 4'b0000);
      cyc_op(1, 3, 8'(8'hB0 + k), (k % 3) != 2, 0, 4'b0000);
    end
    drain(0); drain(3); idle(3);

    // Same-cycle write+pop on empty ring 1: pop refused, next pop returns the write.
    cyc_op(1, 1, 8'h42, 1, 1, 4'b0000);
    check("count1", count[7:4], 1);
    cyc_op(0, 0, 8'h00, 1, 1, 4'b0000);
    idle(3);

    // Flush with a read in flight.
    drain(0);
    for (int k = 0; k < 5; k++) cyc_op(1, 0, 8'(8'h60 + k), 0, 0, 4'b0000);
    cyc_op(0, 0, 8'h00, 1, 0, 4'b0000);
    cyc_op(0, 0, 8'h00, 0, 0, 4'b0001);
    check("flush_empty0", empty[0], 1);
    cyc_op(1, 0, 8'h55, 0, 0, 4'b0000);
    cyc_op(0, 0, 8'h00, 1, 0, 4'b0000);
    idle(3);

`ifdef SONIC_CB_OVERWRITE_EN
    // Overwrite: ten writes into an 8-deep ring drop the two oldest.
    drain(1);
    for (int k = 0; k < 10; k++) cyc_op(1, 1, 8'(k), 0, 0, 4'b0000);
    check("drop_cnt1", drop_cnt[31:16], 2);
    drain(1);
    idle(3);
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 24) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      cyc_op($urandom_range(0, 3) != 0, $urandom_range(0, 3), 8'($urandom),
             $urandom_range(0, 2) != 0, $urandom_range(0, 3), fl);
    end
    idle(3);

    // Reset mid-stream with reads in flight.
    cyc_op(1, 3, 8'hC1, 0, 0, 4'b0000);
    cyc_op(1, 3, 8'hC2, 1, 3, 4'b0000);
    cyc_op(0, 0, 8'h00, 1, 3, 4'b0000);
    wr_valid = 1'b0; rd_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) begin mq[i].delete(); drops[i] = 0; end
    check("midrst_rd_valid", rd_data_valid, 0);
    check("midrst_rd_data", rd_data, 0);
    check_status();
    @(posedge clk);
    @(negedge clk);
    check_status();
    rst = 1'b0;
    cyc_op(1, 2, 8'h77, 0, 0, 4'b0000);
    cyc_op(0, 0, 8'h00, 1, 2, 4'b0000);
    idle(4);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
